sbox_block_sequencer: RTL and testbench
=======================================

# sbox_block_sequencer

Multi-byte substitution sequencer that passes a whole NBYTES-wide block through the single shared combinational `sbox_lookup` instance, one byte per clock. It sits between the block-level cipher datapath and the byte-wide S-box. It accepts a block over a valid/ready handshake, walks every byte through the lookup in forward (encrypt) or inverse (decrypt) mode, and returns the substituted block over a second valid/ready handshake.

## Interface
- NBYTES, default 16: bytes per block; legal range 2..32.
- IDXW, default $clog2(NBYTES): width of the byte index.

- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  source offers a block.
- in_ready  output  1  sequencer can accept a block.
- in_encrypt  input  1  mode for the offered block: 1 = forward S-box, 0 = inverse.
- in_data  input  8*NBYTES  block; byte k is bits [8k+7:8k].
- out_valid  output  1  substituted block is available.
- out_ready  input  1  sink accepts the result.
- out_data  output  8*NBYTES  substituted block, same byte ordering as in_data.
- busy  output  1  high in RUN and DONE.
- byte_idx  output  IDXW  index of the byte currently being looked up; 0 outside RUN.

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - RUN: walks the bytes.
  - DONE: out_valid=1.
- Transitions:
  - IDLE -> RUN on in_valid & in_ready. Capture in_data into the source buffer and in_encrypt into the mode register. Set byte_idx=0.
  - RUN, each cycle: drive S-box address = source byte[byte_idx] and S-box encrypt = mode register. Write the lookup result into result byte[byte_idx] at the clock edge, then increment byte_idx.
  - RUN -> DONE at the edge where byte_idx==NBYTES-1. byte_idx returns to 0; there is no wrap into a second pass.
  - DONE -> IDLE on out_ready. out_data holds stable while out_valid=1 and out_ready=0.
- in_encrypt and in_data are sampled only at the accept edge. Changes during RUN or DONE have no effect.
- in_ready=0 in RUN and DONE. No back-to-back accept in DONE; the next block is taken in IDLE, one cycle after the result handshake.
- out_data keeps its last result after DONE until it is overwritten byte by byte in the next RUN. Sinks qualify it with out_valid only.
- Reset (reset_n=0, any state, including mid-RUN):
  - State -> IDLE; any partial result is discarded.
  - Output values: in_ready=1, out_valid=0, busy=0, byte_idx=0, out_data=0.
  - Source buffer and mode register are cleared (mode clears to 0).

## Timing
- Accept at edge E. RUN spans NBYTES cycles. out_valid rises after edge E+NBYTES.
- Minimum block period, with out_ready held high: NBYTES+2 cycles (accept, NBYTES lookups, handshake).
- The S-box is combinational. The lookup path is source-buffer mux -> sbox_lookup -> result register, within one cycle.
- There is no combinational path from in_valid to in_ready or from out_ready to out_valid. in_ready, out_valid and busy decode directly from the state register.
- Reset assertion takes effect immediately (asynchronous). Release is synchronous to clk through the existing reset synchronizer.

## Structure
- Shared package `sbox_pkg`:
  - State enum {IDLE, RUN, DONE}.
  - Default NBYTES constant (16).
  - Mode constants MODE_ENC=1, MODE_DEC=0.
- Sub-module: one instance of the existing `sbox_lookup` (ports encrypt, address, data_out), which is the only S-box in the block.
- Byte select and result write use an index decode. There is no per-byte S-box replication.

## Test plan
- Reset release, then accept a block of all bytes 0x00 with in_encrypt=1 -> after 16 cycles out_valid=1 and every byte is 0x63; byte_idx steps 0..15 during RUN.
- Block with byte0=0x00, byte1=0x01, byte2=0x53, other bytes 0x00, in_encrypt=1 -> out bytes 0x63, 0x7C, 0xED, rest 0x63. Feed that output back with in_encrypt=0 -> original block restored.
- Toggle in_encrypt and in_data mid-RUN -> result unchanged from the sampled values. in_valid held high during RUN and DONE -> no second accept until IDLE.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable. Raise out_ready -> IDLE next cycle, in_ready=1.
- Assert reset_n=0 at byte_idx=7 -> outputs are immediately in_ready=1, out_valid=0, busy=0, byte_idx=0. A new block after release completes with a correct, full result.
- Back-to-back blocks with out_ready tied high -> accepts spaced exactly NBYTES+2 cycles apart and every result correct.

Source files
------------

// File: rtl/sbox_pkg.sv
// Shared definitions for the S-box block sequencer and its byte-wide lookup.
//   state_t         : sequencer FSM states (IDLE, RUN, DONE)
//   NBYTES_DEFAULT  : default block width in bytes
//   MODE_ENC/DEC    : values of the encrypt/decrypt mode bit
//   gf_* / sbox_*   : GF(2^8) helpers used to build the AES S-box in logic
package sbox_pkg;

  localparam int NBYTES_DEFAULT = 16;

  localparam logic MODE_ENC = 1'b1;
  localparam logic MODE_DEC = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; zero maps to zero, as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

endpackage

// File: rtl/sbox_block_sequencer_if.sv
// Block-level handshake bundle for the S-box sequencer.
//   in_valid/in_ready/in_encrypt/in_data : block offered by the source
//   out_valid/out_ready/out_data         : substituted block returned to the sink
// master = source/sink side, slave = sequencer side.
interface sbox_block_sequencer_if #(
  parameter int NBYTES = sbox_pkg::NBYTES_DEFAULT
);

  logic                  in_valid;
  logic                  in_ready;
  logic                  in_encrypt;
  logic [8*NBYTES-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [8*NBYTES-1:0]   out_data;

  modport master (
    output in_valid, in_encrypt, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_encrypt, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/sbox_lookup.sv
// Combinational byte-wide AES S-box.
//   encrypt  : 1 = forward S-box, 0 = inverse S-box
//   address  : input byte
//   data_out : substituted byte
module sbox_lookup
  import sbox_pkg::*;
(
  input  logic       encrypt,
  input  logic [7:0] address,
  output logic [7:0] data_out
);

  assign data_out = (encrypt == MODE_ENC) ? sbox_fwd(address) : sbox_inv(address);

endmodule

// File: rtl/sbox_block_sequencer.sv
// Walks an NBYTES-wide block through one shared S-box, one byte per clock.
//   clk, reset_n : clock and asynchronous active-low reset
//   bus          : slave side of the block handshake (input block + mode, output block)
//   busy         : high while a block is being processed or waiting to be taken
//   byte_idx     : byte currently being looked up; 0 outside RUN
// NBYTES legal range is 2..32.
module sbox_block_sequencer
  import sbox_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEFAULT,
  parameter int IDXW   = $clog2(NBYTES)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  sbox_block_sequencer_if.slave   bus,
  output logic                    busy,
  output logic [IDXW-1:0]         byte_idx
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  state_t                state_q;
  state_t                state_d;
  logic [8*NBYTES-1:0]   src_q;
  logic [8*NBYTES-1:0]   res_q;
  logic                  mode_q;
  logic [IDXW-1:0]       idx_q;
  logic [7:0]            sel_byte;
  logic [7:0]            sub_byte;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)      state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    if (bus.out_ready)     state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // Handshake outputs decode straight from the state register.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign byte_idx      = idx_q;
  assign bus.out_data  = res_q;

  // --------------------------------------------------------------------------
  // Datapath: index-decoded byte select -> shared S-box -> result byte write
  // --------------------------------------------------------------------------
  always_comb begin
    sel_byte = 8'h00;
    for (int k = 0; k < NBYTES; k++) begin
      if (idx_q == IDXW'(k)) sel_byte = src_q[8*k +: 8];
    end
  end

  sbox_lookup u_sbox (
    .encrypt  (mode_q),
    .address  (sel_byte),
    .data_out (sub_byte)
  );

  // NOTE: the block-wide buffers are reset here because out_data must read
  // zero after reset and a half-written block must not leak out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q  <= '0;
      res_q  <= '0;
      mode_q <= MODE_DEC;
      idx_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            src_q  <= bus.in_data;
            mode_q <= bus.in_encrypt;
            idx_q  <= '0;
          end
        end
        RUN: begin
          for (int k = 0; k < NBYTES; k++) begin
            if (idx_q == IDXW'(k)) res_q[8*k +: 8] <= sub_byte;
          end
          // Single pass only: the last byte sends the index home.
          idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sbox_block_sequencer.sv
// Self-checking bench for sbox_block_sequencer: randomized blocks compared
// against an S-box table model built by the classic generator walk.
module tb_sbox_block_sequencer;

  localparam int NB = 16;
  localparam int W  = 8 * NB;
  localparam int IW = $clog2(NB);

  logic          clk     = 1'b0;
  logic          reset_n = 1'b0;
  logic          busy;
  logic [IW-1:0] byte_idx;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  sbox_block_sequencer_if #(.NBYTES(NB)) bus ();

  sbox_block_sequencer #(.NBYTES(NB)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus.slave),
    .busy     (busy),
    .byte_idx (byte_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  // Walk p over powers of 3 and q over powers of 1/3, so q is always 1/p.
  function automatic void build_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ 8'(p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ 8'(q << 1);
      q = q ^ 8'(q << 2);
      q = q ^ 8'(q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
      fwd_tab[p] = x ^ 8'h63;
    end while (p != 8'h01);
    fwd_tab[0] = 8'h63;
    for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);
  endfunction

  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic enc);
    logic [W-1:0] r;
    for (int k = 0; k < NB; k++)
      r[8*k +: 8] = enc ? fwd_tab[d[8*k +: 8]] : inv_tab[d[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [W-1:0] rand_block();
    logic [W-1:0] r;
    for (int k = 0; k < NB; k++) r[8*k +: 8] = 8'($urandom);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one block, follow it through RUN and DONE, and take the result.
  task automatic send_block(input logic [W-1:0] data, input logic enc,
                            input int ready_delay, input bit scramble,
                            input bit keep_valid, output logic [W-1:0] got,
                            output int acc_cyc);
    logic [W-1:0] exp;
    int guard;
    exp = model(data, enc);
    bus.in_data    = data;
    bus.in_encrypt = enc;
    bus.in_valid   = 1'b1;
    bus.out_ready  = (ready_delay == 0);
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      step();
      guard++;
    end
    check("accept_wait", W'(guard < 100), W'(1));
    step();
    acc_cyc = cyc;
    if (!keep_valid) bus.in_valid = 1'b0;
    for (int k = 0; k < NB; k++) begin
      check("run_idx", W'(byte_idx), W'(k));
      check("run_flags", W'({busy, bus.in_ready, bus.out_valid}), W'(3'b100));
      if (scramble) begin
        bus.in_data    = rand_block();
        bus.in_encrypt = 1'($urandom);
      end
      step();
    end
    check("done_flags", W'({busy, bus.in_ready, bus.out_valid}), W'(3'b101));
    check("result", bus.out_data, exp);
    got = bus.out_data;
    for (int d = 0; d < ready_delay; d++) begin
      step();
      check("hold_valid", W'({bus.out_valid, bus.in_ready}), W'(2'b10));
      check("hold_data", bus.out_data, exp);
    end
    bus.out_ready = 1'b1;
    step();
    check("idle_flags", W'({busy, bus.in_ready, bus.out_valid}), W'(3'b010));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] blk, got, got2, exp_c;
    int acc, prev_acc, guard;

    build_tables();
    bus.in_valid   = 1'b0;
    bus.in_encrypt = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;

    // Reset state.
    #2;
    check("reset_flags", W'({bus.in_ready, bus.out_valid, busy}), W'(3'b100));
    check("reset_idx", W'(byte_idx), '0);
    check("reset_data", bus.out_data, '0);
    #21 reset_n = 1'b1;
    step();

    // All-zero block, forward mode.
    send_block('0, 1'b1, 0, 1'b0, 1'b0, got, acc);
    check("zero_const", got, {NB{8'h63}});

    // Known bytes, then round trip through the inverse.
    blk = '0;
    blk[15:8]  = 8'h01;
    blk[23:16] = 8'h53;
    exp_c = {NB{8'h63}};
    exp_c[15:8]  = 8'h7c;
    exp_c[23:16] = 8'hed;
    send_block(blk, 1'b1, 0, 1'b0, 1'b0, got, acc);
    check("known_const", got, exp_c);
    send_block(got, 1'b0, 0, 1'b0, 1'b0, got2, acc);
    check("roundtrip", got2, blk);

    // Inputs scrambled mid-block with in_valid held high; result held 5 cycles.
    send_block(rand_block(), 1'b1, 5, 1'b1, 1'b1, got, acc);
    bus.in_valid = 1'b0;
    send_block(rand_block(), 1'b0, 2, 1'b1, 1'b1, got, acc);
    bus.in_valid = 1'b0;

    // Reset in the middle of a block.
    bus.in_data    = rand_block();
    bus.in_encrypt = 1'b1;
    bus.in_valid   = 1'b1;
    bus.out_ready  = 1'b0;
    step();
    bus.in_valid = 1'b0;
    guard = 0;
    while (byte_idx != IW'(7) && guard < 40) begin
      step();
      guard++;
    end
    check("reach_idx7", W'(byte_idx), W'(7));
    #2 reset_n = 1'b0;
    #1;
    check("midrst_flags", W'({bus.in_ready, bus.out_valid, busy}), W'(3'b100));
    check("midrst_idx", W'(byte_idx), '0);
    check("midrst_data", bus.out_data, '0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    step();
    send_block(rand_block(), 1'b1, 1, 1'b0, 1'b0, got, acc);

    // Back-to-back blocks, out_ready high, spacing NB+2.
    prev_acc = -1;
    for (int b = 0; b < 6; b++) begin
      send_block(rand_block(), 1'($urandom), 0, 1'b0, 1'b1, got, acc);
      if (prev_acc >= 0) check("b2b_spacing", W'(acc - prev_acc), W'(NB + 2));
      prev_acc = acc;
    end
    bus.in_valid = 1'b0;

    // Random mix of modes and sink stalls.
    for (int b = 0; b < 8; b++)
      send_block(rand_block(), 1'($urandom), int'($urandom_range(0, 3)),
                 1'($urandom), 1'b0, got, acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
